// File: rtl/sync_handshake_rx.sv
// Four-phase req/ack receiver: synchronizes async_req into clk and delivers
// the source bus as a valid/ready word, returning a registered acknowledge.
module sync_handshake_rx #(
    parameter int N           = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             async_req,
    input  logic [N-1:0]     async_data,
    output logic             ack,
    output logic             out_valid,
    output logic [N-1:0]     out_data,
    input  logic             out_ready,
    output logic             err,
    input  logic             err_clr,
    output logic [CNT_W-1:0] xfer_count
);

    typedef enum logic [1:0] {
        IDLE,
        VALID,
        ACK
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    state_t                 state_q;
    logic                   ack_q;
    logic                   valid_q;
    logic [N-1:0]           data_q;
    logic                   err_q;
    logic                   err_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_req};
        end
    end

    assign req_s = sync_q[SYNC_STAGES-1];

    // A withdrawal seen in VALID outranks a coincident clear.
    assign err_d = (err_q & ~err_clr) | ((state_q == VALID) & ~req_s);
    assign cnt_d = cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            err_q <= err_d;
            unique case (state_q)
                IDLE: begin
                    if (req_s) begin
                        data_q  <= async_data;
                        valid_q <= 1'b1;
                        state_q <= VALID;
                    end
                end
                VALID: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        ack_q   <= 1'b1;
                        cnt_q   <= cnt_d;
                        state_q <= ACK;
                    end
                end
                ACK: begin
                    if (!req_s) begin
                        ack_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    ack_q   <= 1'b0;
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack        = ack_q;
    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign err        = err_q;
    assign xfer_count = cnt_q;

endmodule
